axis_width_converter: RTL and testbench



---
 rtl/axis_width_pkg.sv | 23 ++
 rtl/axis_register_slice.sv | 72 +++++++
 rtl/axis_width_converter.sv | 206 ++++++++++++++++++++
 tb/tb_axis_width_converter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_width_pkg.sv
// Shared types and elaboration helpers for the AXI-Stream width converter.
package axis_width_pkg;

  // Conversion direction chosen from the two tdata widths.
  typedef enum logic [1:0] {DOWN, UP, PASS} mode_e;

  // Downsizer: holding nothing, or emitting slices of a stored beat.
  typedef enum logic {EMPTY, EMIT} down_state_e;

  // Upsizer: collecting lanes, or holding a finished word for the consumer.
  typedef enum logic {ACCUM, FULL} up_state_e;

  function automatic mode_e calc_mode(input int s_w, input int m_w);
    if (s_w > m_w) return DOWN;
    if (s_w < m_w) return UP;
    return PASS;
  endfunction

  function automatic int calc_ratio(input int s_w, input int m_w);
    return (s_w >= m_w) ? (s_w / m_w) : (m_w / s_w);
  endfunction

endpackage

// File: rtl/axis_register_slice.sv
// One-stage valid/ready register carrying tdata, tkeep, tlast and tuser.
module axis_register_slice #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEEP_W-1:0] s_keep,
  input  logic              s_last,
  input  logic              s_user,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [KEEP_W-1:0] m_keep,
  output logic              m_last,
  output logic              m_user,
  output logic              m_valid,
  input  logic              m_ready
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;
  logic              user_q, user_d;

  // A new beat may enter whenever the slot is empty or is draining this cycle.
  assign s_ready = !valid_q || m_ready;

  // Load on input handshake, otherwise empty the slot once the consumer takes it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    user_d  = user_q;
    if (s_valid && s_ready) begin
      valid_d = 1'b1;
      data_d  = s_data;
      keep_d  = s_keep;
      last_d  = s_last;
      user_d  = s_user;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_keep  = keep_q;
  assign m_last  = last_q;
  assign m_user  = user_q;

endmodule

// File: rtl/axis_width_converter.sv
// AXI-Stream data-width converter: downsize, upsize or pass-through.
module axis_width_converter
  import axis_width_pkg::*;
#(
  parameter int S_DATA_WIDTH = 16,
  parameter int M_DATA_WIDTH = 8,
  parameter bit LSB_FIRST    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [S_DATA_WIDTH-1:0]   s_tdata,
  input  logic [S_DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  input  logic                      s_tuser,
  output logic [M_DATA_WIDTH-1:0]   m_tdata,
  output logic [M_DATA_WIDTH/8-1:0] m_tkeep,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      m_tuser
);

  localparam mode_e MODE = calc_mode(S_DATA_WIDTH, M_DATA_WIDTH);
  localparam int    R    = calc_ratio(S_DATA_WIDTH, M_DATA_WIDTH);
  localparam int    IW   = (R > 1) ? $clog2(R) : 1;
  localparam int    SK   = S_DATA_WIDTH / 8;
  localparam int    MK   = M_DATA_WIDTH / 8;

  if ((S_DATA_WIDTH % 8) != 0 || (M_DATA_WIDTH % 8) != 0 ||
      ((S_DATA_WIDTH % M_DATA_WIDTH) != 0 && (M_DATA_WIDTH % S_DATA_WIDTH) != 0)) begin : g_bad_width
    $error("axis_width_converter: widths must be byte multiples and integer ratios");
  end

  // Ready from the active engine, held low for the whole reset period.
  logic s_ready_raw;
  assign s_tready = s_ready_raw & rst_n;

  if (MODE == DOWN) begin : g_down
    down_state_e             state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d, final_q, final_d, slice_sel, last_used;
    logic [S_DATA_WIDTH-1:0] data_q, data_d;
    logic [SK-1:0]           keep_q, keep_d;
    logic                    last_q, last_d, user_q, user_d;
    logic                    accept, done;

    // Send-order index mapped to the physical slice of the stored beat.
    assign slice_sel = LSB_FIRST ? idx_q : IW'(R - 1) - idx_q;

    // Last slice in send order that carries any byte of the incoming beat.
    always_comb begin
      last_used = '0;
      for (int k = 0; k < R; k++) begin
        if (|s_tkeep[(LSB_FIRST ? k : R - 1 - k) * MK +: MK]) last_used = IW'(k);
      end
    end

    assign m_tvalid    = (state_q == EMIT);
    assign m_tdata     = data_q[slice_sel * M_DATA_WIDTH +: M_DATA_WIDTH];
    assign m_tkeep     = keep_q[slice_sel * MK +: MK];
    assign m_tlast     = m_tvalid && last_q && (idx_q == final_q);
    assign m_tuser     = user_q;
    assign done        = m_tvalid && m_tready && (idx_q == final_q);
    assign s_ready_raw = (state_q == EMPTY) || done;
    assign accept      = s_tvalid && s_tready;

    // Store a beat on accept, step through slices, go idle after the final one.
    always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      final_d = final_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      user_d  = user_q;
      if (accept) begin
        state_d = EMIT;
        idx_d   = '0;
        data_d  = s_tdata;
        keep_d  = s_tkeep;
        last_d  = s_tlast;
        user_d  = s_tuser;
        final_d = s_tlast ? last_used : IW'(R - 1);
      end else if (done) begin
        state_d = EMPTY;
        idx_d   = '0;
      end else if (m_tvalid && m_tready) begin
        idx_d = idx_q + IW'(1);
      end
    end

    // Downsizer state with synchronous active-low reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= EMPTY;
        idx_q   <= '0;
        final_q <= '0;
        data_q  <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
        user_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        idx_q   <= idx_d;
        final_q <= final_d;
        data_q  <= data_d;
        keep_q  <= keep_d;
        last_q  <= last_d;
        user_q  <= user_d;
      end
    end
  end else if (MODE == UP) begin : g_up
    // The output slice being occupied is the FULL phase; lane_q tracks ACCUM.
    logic [IW-1:0]           lane_q, lane_d, lane_pos;
    logic [M_DATA_WIDTH-1:0] acc_data_q, acc_data_d, word_data;
    logic [MK-1:0]           acc_keep_q, acc_keep_d, word_keep;
    logic                    acc_user_q, acc_user_d, word_user;
    logic                    closing, accept, up_ready;

    assign lane_pos    = LSB_FIRST ? lane_q : IW'(R - 1) - lane_q;
    assign closing     = (lane_q == IW'(R - 1)) || s_tlast;
    assign accept      = s_tvalid && s_tready;
    assign s_ready_raw = up_ready;

    // Word as it would look with the current input beat dropped into its lane.
    always_comb begin
      word_data = acc_data_q;
      word_keep = acc_keep_q;
      word_data[lane_pos * S_DATA_WIDTH +: S_DATA_WIDTH] = s_tdata;
      word_keep[lane_pos * SK +: SK] = s_tkeep;
      word_user = acc_user_q | s_tuser;
    end

    // Keep filling lanes; a closing beat hands the word on and restarts empty.
    always_comb begin
      lane_d     = lane_q;
      acc_data_d = acc_data_q;
      acc_keep_d = acc_keep_q;
      acc_user_d = acc_user_q;
      if (accept) begin
        if (closing) begin
          lane_d     = '0;
          acc_data_d = '0;
          acc_keep_d = '0;
          acc_user_d = 1'b0;
        end else begin
          lane_d     = lane_q + IW'(1);
          acc_data_d = word_data;
          acc_keep_d = word_keep;
          acc_user_d = word_user;
        end
      end
    end

    // Accumulator with synchronous active-low reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        lane_q     <= '0;
        acc_data_q <= '0;
        acc_keep_q <= '0;
        acc_user_q <= 1'b0;
      end else begin
        lane_q     <= lane_d;
        acc_data_q <= acc_data_d;
        acc_keep_q <= acc_keep_d;
        acc_user_q <= acc_user_d;
      end
    end

    axis_register_slice #(.DATA_W(M_DATA_WIDTH), .KEEP_W(MK)) u_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  (word_data),
      .s_keep  (word_keep),
      .s_last  (s_tlast),
      .s_user  (word_user),
      .s_valid (accept && closing),
      .s_ready (up_ready),
      .m_data  (m_tdata),
      .m_keep  (m_tkeep),
      .m_last  (m_tlast),
      .m_user  (m_tuser),
      .m_valid (m_tvalid),
      .m_ready (m_tready)
    );
  end else begin : g_pass
    axis_register_slice #(.DATA_W(M_DATA_WIDTH), .KEEP_W(MK)) u_pass (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  (s_tdata),
      .s_keep  (s_tkeep),
      .s_last  (s_tlast),
      .s_user  (s_tuser),
      .s_valid (s_tvalid),
      .s_ready (s_ready_raw),
      .m_data  (m_tdata),
      .m_keep  (m_tkeep),
      .m_last  (m_tlast),
      .m_user  (m_tuser),
      .m_valid (m_tvalid),
      .m_ready (m_tready)
    );
  end

endmodule

// File: tb/tb_axis_width_converter.sv
// Bench for axis_width_converter across down, up and pass configurations.
module tb_axis_width_converter;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  localparam int ND = 6;
  int cfg_sw  [ND] = '{16, 16, 32, 8, 16, 8};
  int cfg_mw  [ND] = '{8, 8, 8, 32, 16, 32};
  int cfg_lsb [ND] = '{1, 0, 1, 1, 1, 0};

  logic        clk;
  logic        rst_n;
  logic [31:0] s_data  [ND];
  logic [3:0]  s_keep  [ND];
  logic        s_valid [ND];
  logic        s_last  [ND];
  logic        s_user  [ND];
  logic        m_ready [ND];

  wire [7:0]  m_data0, m_data1, m_data2;
  wire [31:0] m_data3, m_data5;
  wire [15:0] m_data4;
  wire [0:0]  m_keep0, m_keep1, m_keep2;
  wire [3:0]  m_keep3, m_keep5;
  wire [1:0]  m_keep4;
  wire [ND-1:0] mv_w, ml_w, mu_w, sr_w;

  logic [31:0] md [ND];
  logic [3:0]  mk [ND];
  logic        mv [ND];
  logic        ml [ND];
  logic        mu [ND];
  logic        sr [ND];

  int total = 0;
  int bad   = 0;

  beat_t       stim_q [$];
  beat_t       exp_q  [$];
  int          up_cnt;
  logic [31:0] up_data;
  logic [3:0]  up_keep;
  logic        up_user;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gather the differently sized DUT outputs into uniform arrays.
  always_comb begin
    md[0] = 32'(m_data0); md[1] = 32'(m_data1); md[2] = 32'(m_data2);
    md[3] = m_data3;      md[4] = 32'(m_data4); md[5] = m_data5;
    mk[0] = 4'(m_keep0);  mk[1] = 4'(m_keep1);  mk[2] = 4'(m_keep2);
    mk[3] = m_keep3;      mk[4] = 4'(m_keep4);  mk[5] = m_keep5;
    for (int i = 0; i < ND; i++) begin
      mv[i] = mv_w[i];
      ml[i] = ml_w[i];
      mu[i] = mu_w[i];
      sr[i] = sr_w[i];
    end
  end

  axis_width_converter #(.S_DATA_WIDTH(16), .M_DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_data[0][15:0]), .s_tkeep(s_keep[0][1:0]),
    .s_tvalid(s_valid[0]), .s_tready(sr_w[0]), .s_tlast(s_last[0]), .s_tuser(s_user[0]),
    .m_tdata(m_data0), .m_tkeep(m_keep0), .m_tvalid(mv_w[0]), .m_tready(m_ready[0]),
    .m_tlast(ml_w[0]), .m_tuser(mu_w[0]));

  axis_width_converter #(.S_DATA_WIDTH(16), .M_DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_data[1][15:0]), .s_tkeep(s_keep[1][1:0]),
    .s_tvalid(s_valid[1]), .s_tready(sr_w[1]), .s_tlast(s_last[1]), .s_tuser(s_user[1]),
    .m_tdata(m_data1), .m_tkeep(m_keep1), .m_tvalid(mv_w[1]), .m_tready(m_ready[1]),
    .m_tlast(ml_w[1]), .m_tuser(mu_w[1]));

  axis_width_converter #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_data[2]), .s_tkeep(s_keep[2]),
    .s_tvalid(s_valid[2]), .s_tready(sr_w[2]), .s_tlast(s_last[2]), .s_tuser(s_user[2]),
    .m_tdata(m_data2), .m_tkeep(m_keep2), .m_tvalid(mv_w[2]), .m_tready(m_ready[2]),
    .m_tlast(ml_w[2]), .m_tuser(mu_w[2]));

  axis_width_converter #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(32), .LSB_FIRST(1'b1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_data[3][7:0]), .s_tkeep(s_keep[3][0:0]),
    .s_tvalid(s_valid[3]), .s_tready(sr_w[3]), .s_tlast(s_last[3]), .s_tuser(s_user[3]),
    .m_tdata(m_data3), .m_tkeep(m_keep3), .m_tvalid(mv_w[3]), .m_tready(m_ready[3]),
    .m_tlast(ml_w[3]), .m_tuser(mu_w[3]));

  axis_width_converter #(.S_DATA_WIDTH(16), .M_DATA_WIDTH(16), .LSB_FIRST(1'b1)) u_d4 (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_data[4][15:0]), .s_tkeep(s_keep[4][1:0]),
    .s_tvalid(s_valid[4]), .s_tready(sr_w[4]), .s_tlast(s_last[4]), .s_tuser(s_user[4]),
    .m_tdata(m_data4), .m_tkeep(m_keep4), .m_tvalid(mv_w[4]), .m_tready(m_ready[4]),
    .m_tlast(ml_w[4]), .m_tuser(mu_w[4]));

  axis_width_converter #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(32), .LSB_FIRST(1'b0)) u_d5 (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_data[5][7:0]), .s_tkeep(s_keep[5][0:0]),
    .s_tvalid(s_valid[5]), .s_tready(sr_w[5]), .s_tlast(s_last[5]), .s_tuser(s_user[5]),
    .m_tdata(m_data5), .m_tkeep(m_keep5), .m_tvalid(mv_w[5]), .m_tready(m_ready[5]),
    .m_tlast(ml_w[5]), .m_tuser(mu_w[5]));

  function automatic logic [31:0] low_mask(input int bits);
    return (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
  endfunction

  // Count one comparison and report it when observed and required differ.
  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed %h required %h", tag, actual, expected);
    end
  endtask

  // Reference model: what the consumer must see for one accepted input beat.
  task automatic model_accept(input int d, input beat_t b);
    int    sw, mw, r, nb, stop, pos;
    beat_t o;
    sw = cfg_sw[d];
    mw = cfg_mw[d];
    if (sw > mw) begin
      r    = sw / mw;
      nb   = mw / 8;
      stop = r - 1;
      if (b.last) begin
        stop = 0;
        for (int k = 0; k < r; k++) begin
          pos = (cfg_lsb[d] != 0) ? k : r - 1 - k;
          if (((32'(b.keep) >> (pos * nb)) & low_mask(nb)) != 0) stop = k;
        end
      end
      for (int k = 0; k <= stop; k++) begin
        pos    = (cfg_lsb[d] != 0) ? k : r - 1 - k;
        o.data = (b.data >> (pos * mw)) & low_mask(mw);
        o.keep = 4'((32'(b.keep) >> (pos * nb)) & low_mask(nb));
        o.last = b.last && (k == stop);
        o.user = b.user;
        exp_q.push_back(o);
      end
    end else if (sw < mw) begin
      r   = mw / sw;
      nb  = sw / 8;
      pos = (cfg_lsb[d] != 0) ? up_cnt : r - 1 - up_cnt;
      up_data = up_data | ((b.data & low_mask(sw)) << (pos * sw));
      up_keep = up_keep | 4'((32'(b.keep) & low_mask(nb)) << (pos * nb));
      up_user = up_user | b.user;
      up_cnt++;
      if (up_cnt == r || b.last) begin
        o.data = up_data;
        o.keep = up_keep;
        o.last = b.last;
        o.user = up_user;
        exp_q.push_back(o);
        up_cnt  = 0;
        up_data = '0;
        up_keep = '0;
        up_user = 1'b0;
      end
    end else begin
      o.data = b.data & low_mask(sw);
      o.keep = 4'(32'(b.keep) & low_mask(sw / 8));
      o.last = b.last;
      o.user = b.user;
      exp_q.push_back(o);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    up_cnt  = 0;
    up_data = '0;
    up_keep = '0;
    up_user = 1'b0;
  endtask

  // Stream stim_q into one DUT. mode 0: ready always, 1: ready toggles, 2: random ready and valid gaps.
  task automatic apply_stimulus(input int d, input int mode, output int cycles);
    int    sent;
    int    budget;
    logic  consumed;
    beat_t cur;
    sent     = 0;
    cycles   = 0;
    consumed = 1'b0;
    budget   = 20 * stim_q.size() + 40;
    while ((sent < stim_q.size() || exp_q.size() > 0) && cycles < budget) begin
      @(negedge clk);
      if (consumed) s_valid[d] = 1'b0;
      consumed = 1'b0;
      if (!s_valid[d] && sent < stim_q.size() && (mode != 2 || $urandom_range(0, 3) != 0)) begin
        cur        = stim_q[sent];
        s_data[d]  = cur.data;
        s_keep[d]  = cur.keep;
        s_last[d]  = cur.last;
        s_user[d]  = cur.user;
        s_valid[d] = 1'b1;
      end
      case (mode)
        0:       m_ready[d] = 1'b1;
        1:       m_ready[d] = (cycles % 2 == 0);
        default: m_ready[d] = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      if (mv[d]) begin
        if (exp_q.size() == 0) begin
          check_output($sformatf("d%0d_unexpected_beat", d), 32'(mv[d]), 32'd0);
        end else begin
          check_output($sformatf("d%0d_tdata", d), md[d], exp_q[0].data);
          check_output($sformatf("d%0d_tkeep", d), 32'(mk[d]), 32'(exp_q[0].keep));
          check_output($sformatf("d%0d_tlast", d), 32'(ml[d]), 32'(exp_q[0].last));
          check_output($sformatf("d%0d_tuser", d), 32'(mu[d]), 32'(exp_q[0].user));
          if (m_ready[d]) void'(exp_q.pop_front());
        end
      end
      if (s_valid[d] && sr[d]) begin
        model_accept(d, stim_q[sent]);
        sent++;
        consumed = 1'b1;
      end
      @(posedge clk);
      cycles++;
    end
    @(negedge clk);
    s_valid[d] = 1'b0;
    check_output($sformatf("d%0d_leftover", d), 32'(exp_q.size() + stim_q.size() - sent), 32'd0);
    stim_q.delete();
  endtask

  task automatic add_beat(input logic [31:0] data, input logic [3:0] keep, input logic last, input logic user);
    beat_t b;
    b.data = data;
    b.keep = keep;
    b.last = last;
    b.user = user;
    stim_q.push_back(b);
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < ND; i++) begin
      s_data[i]  = '0;
      s_keep[i]  = '0;
      s_valid[i] = 1'b0;
      s_last[i]  = 1'b0;
      s_user[i]  = 1'b0;
      m_ready[i] = 1'b1;
    end
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      check_output($sformatf("d%0d_reset_tvalid", i), 32'(mv[i]), 32'd0);
      check_output($sformatf("d%0d_reset_tready", i), 32'(sr[i]), 32'd0);
      check_output($sformatf("d%0d_reset_tdata", i), md[i], 32'd0);
      check_output($sformatf("d%0d_reset_tlast", i), 32'(ml[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) check_output($sformatf("d%0d_ready_after_reset", i), 32'(sr[i]), 32'd1);

    $display("[TB] directed downsizing cases");
    add_beat(32'h6971, 4'b0011, 1'b1, 1'b0);
    apply_stimulus(0, 0, cyc);
    check_output("d0_single_beat_cycles", 32'(cyc), 32'd3);
    add_beat(32'h6971, 4'b0011, 1'b1, 1'b0);
    apply_stimulus(1, 0, cyc);
    add_beat(32'hAABBCCDD, 4'b0011, 1'b1, 1'b0);
    add_beat(32'hAABBCCDD, 4'b0011, 1'b0, 1'b0);
    add_beat(32'h11223344, 4'b0000, 1'b1, 1'b1);
    apply_stimulus(2, 0, cyc);

    $display("[TB] directed upsizing case");
    add_beat(32'h01, 4'b1, 1'b0, 1'b0);
    add_beat(32'h02, 4'b1, 1'b0, 1'b0);
    add_beat(32'h03, 4'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add_beat(32'h10 + 32'(i), 4'b1, 1'b0, 1'b0);
    apply_stimulus(3, 0, cyc);
    check_output("d3_upsize_cycles", 32'(cyc), 32'd8);

    $display("[TB] continuous downsizing, free-running and stalled");
    for (int i = 0; i < 3; i++) add_beat(32'hA0B0 + 32'(i * 'h0101), 4'b0011, (i == 2), 1'b0);
    apply_stimulus(0, 0, cyc);
    check_output("d0_back_to_back_cycles", 32'(cyc), 32'd7);
    for (int i = 0; i < 3; i++) add_beat(32'h1122 + 32'(i * 'h1111), 4'b0011, (i == 2), 1'b0);
    apply_stimulus(0, 1, cyc);

    $display("[TB] reset in the middle of a packet");
    @(negedge clk);
    s_data[0]  = 32'h6971;
    s_keep[0]  = 4'b0011;
    s_last[0]  = 1'b1;
    s_user[0]  = 1'b0;
    s_valid[0] = 1'b1;
    m_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid[0] = 1'b0;
    #1;
    check_output("rst_first_byte", md[0], 32'h71);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_tvalid_low", 32'(mv[0]), 32'd0);
    check_output("rst_tready_low", 32'(sr[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    check_output("rst_tready_release", 32'(sr[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_output("rst_no_stale_byte", 32'(mv[0]), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("[TB] randomized streams on every configuration");
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 24; i++) begin
        add_beat($urandom & low_mask(cfg_sw[d]),
                 4'($urandom & low_mask(cfg_sw[d] / 8)),
                 (i == 23) || ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
      end
      apply_stimulus(d, 2, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
